wb_regfile: RTL

- Writeback stage and register file of the mips32 pipeline; the consumer end of the MEM/WB pipeline register.
- Takes the MEM/WB outputs (3-bit WB control, pc, memory data, ALU result, destination register) and selects the writeback value.
- Commits that value into a 32x32 register file and serves the two ID-stage read ports.
- Also exports the current and previous-cycle writebacks for the forwarding unit, plus a committed-write counter.

---
 rtl/wb_regfile.sv | 105 ++++++++++
 1 files changed

// File: rtl/wb_regfile.sv
// MIPS32 writeback stage: selects the writeback value, commits it into a 2**ADDR_W x DATA_W
// register file, and exports the writeback history for forwarding. Optional macro: REGFILE_BYPASS_EN.
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        controlIn,
    input  logic [DATA_W-1:0] pcIn,
    input  logic [DATA_W-1:0] memDataIn,
    input  logic [DATA_W-1:0] aluResultIn,
    input  logic [ADDR_W-1:0] destRegIn,
    input  logic [ADDR_W-1:0] readReg1,
    input  logic [ADDR_W-1:0] readReg2,
    output logic [DATA_W-1:0] readData1,
    output logic [DATA_W-1:0] readData2,
    output logic              wbWrite,
    output logic [ADDR_W-1:0] wbReg,
    output logic [DATA_W-1:0] wbData,
    output logic              lastValid,
    output logic [ADDR_W-1:0] lastReg,
    output logic [DATA_W-1:0] lastData,
    output logic [31:0]       writeCount
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef struct packed {
        logic link;
        logic mem_to_reg;
        logic reg_write;
    } wb_ctrl_t;

    wb_ctrl_t          ctrl;
    logic [DATA_W-1:0] regs [NUM_REGS];

    assign ctrl = wb_ctrl_t'(controlIn);

    // Register 0 is hardwired; a known-0 RegWrite masks any X on the other inputs.
    assign wbWrite = ctrl.reg_write & (destRegIn != '0);
    assign wbReg   = destRegIn;

    // NOTE: wbData gets a default before the priority chain so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        wbData = aluResultIn;
        if (ctrl.link) begin
            wbData = pcIn;
        end else if (ctrl.mem_to_reg) begin
            wbData = memDataIn;
        end
    end

    // NOTE: this array is built from flops with an async reset because the file must read as
    // all-zero straight out of reset; it can therefore not be mapped onto a RAM macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (wbWrite && (destRegIn == ADDR_W'(i))) begin
                    regs[i] <= wbData;
                end
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples the
    // pre-edge values of wbWrite/wbData, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lastValid  <= 1'b0;
            lastReg    <= '0;
            lastData   <= '0;
            writeCount <= '0;
        end else begin
            lastValid <= wbWrite;
            if (wbWrite) begin
                lastReg    <= wbReg;
                lastData   <= wbData;
                writeCount <= writeCount + 32'd1;
            end
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] idx);
        if (idx == '0) begin
            return '0;
        end
`ifdef REGFILE_BYPASS_EN
        // Write-through lets an ID-stage read see the value committing this cycle.
        if (wbWrite && (idx == destRegIn)) begin
            return wbData;
        end
`endif
        return regs[idx];
    endfunction

    assign readData1 = read_port(readReg1);
    assign readData2 = read_port(readReg2);

endmodule
